id_stage_pipe: RTL and testbench
================================

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameters SHALL be: XLEN, 32, integer/FP data width; X0_ZERO, 1, integer register 0 reads as zero and ignores writes.
REQ-002 Ports SHALL be: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-low reset.
REQ-003 Ports SHALL be: if_valid in 1, if_instr in 32, if_pc_plus4 in XLEN, if_ready out 1 (IF/ID handshake).
REQ-004 Ports SHALL be: wb_int_we in 1, wb_fp_we in 1, wb_rd_addr in 5, wb_int_data in XLEN, wb_fp_data in XLEN (writeback).
REQ-005 Ports SHALL be: ex_ld_pend in 1, ex_ld_rd in 5, ex_ld_fp in 1 (load in EX: destination and file), flush in 1.
REQ-006 Ports SHALL be: ex_ready in 1; ex_valid out 1; ex_instr out 32; ex_pc_plus4 out XLEN; ex_rd_addr out 5.
REQ-007 Ports SHALL be: ex_int_rs1, ex_int_rs2, ex_fp_rs1, ex_fp_rs2 out XLEN each; stall out 1.

Function
REQ-008 rs1 = if_instr[19:15], rs2 = if_instr[24:20], rd = if_instr[11:7].
REQ-009 Block SHALL contain a 32 x XLEN integer file and a 32 x XLEN FP file, each 2 async read ports, 1 sync write port.
REQ-010 Writes occur at clk rise when the respective we is 1; integer writes to address 0 dropped when X0_ZERO=1.
REQ-011 Write-through bypass: read address equal to wb_rd_addr with matching we returns same-cycle wb data (integer addr 0 excluded when X0_ZERO=1).
REQ-012 hazard = ex_ld_pend & ((ex_ld_rd==rs1) | (ex_ld_rd==rs2)), file-matched via ex_ld_fp; integer match on register 0 never hazards when X0_ZERO=1.
REQ-013 stall = if_valid & hazard; combinational.
REQ-014 advance = !ex_valid | ex_ready; if_ready = advance & !hazard & !flush.
REQ-015 On advance & !flush: ex_valid <= if_valid & !hazard; data registers load decoded values only when if_valid & !hazard, otherwise hold (bubble).
REQ-016 When !advance: all ex_* outputs hold unchanged (backpressure); no IF input consumed.
REQ-017 flush=1: ex_valid <= 0 next edge regardless of ex_ready; if_ready=0; writeback still performed.
REQ-018 Latency: instruction accepted at edge N appears on ex_* after edge N (1 cycle); throughput 1/cycle with no hazard and ex_ready=1.
REQ-019 Simultaneous hazard and writeback resolving it: hazard wins (stall), bypass data used on the following cycle.

Reset
REQ-020 rst low SHALL asynchronously clear ex_valid, ex_instr, ex_pc_plus4, ex_rd_addr, all ex_*_rs* to 0.
REQ-021 rst low SHALL clear every register of both files to 0; writes ignored while rst low.
REQ-022 Reset mid-transfer discards the held instruction; first accept allowed on first edge after rst deasserts.

Configuration
REQ-023 Macro ID_STAGE_FP_RF_EN defined: FP file, FP bypass, FP hazard compare present as specified.
REQ-024 Macro undefined: no FP storage; ex_fp_rs1/ex_fp_rs2 tied 0; wb_fp_we, wb_fp_data ignored; ex_ld_fp=1 never hazards.

Verification
REQ-025 Write x5=0x1234 via WB, then issue instr rs1=5 -> next cycle ex_int_rs1=0x1234, ex_valid=1.
REQ-026 WB write x7=0xCAFE same cycle as issue with rs2=7 -> ex_int_rs2=0xCAFE (bypass); write x0=0xFFFF then read x0 -> 0.
REQ-027 ex_ld_pend=1, ex_ld_rd=3, ex_ld_fp=0, instr rs1=3 -> stall=1, if_ready=0, ex_valid=0 next cycle; drop ex_ld_pend -> instr issues.
REQ-028 ex_valid=1, ex_ready=0 for 3 cycles with if_valid=1 -> ex_* unchanged, if_ready=0; ex_ready=1 -> new instr next cycle.
REQ-029 flush=1 with ex_valid=1 and if_valid=1 -> ex_valid=0 next cycle, instr not accepted; rst low mid-stream -> all outputs 0 immediately.
REQ-030 With ID_STAGE_FP_RF_EN: FP write f2=0x3F800000, read rs1=2 -> ex_fp_rs1=0x3F800000; without macro -> 0.

Source files
------------

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - ID stage: integer/FP register files, load-use hazard detect, ID/EX register
// Optional FP file, bypass and hazard compare enabled by `define ID_STAGE_FP_RF_EN.
module id_stage_pipe #(
  parameter int XLEN    = 32,
  parameter int X0_ZERO = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc_plus4,
  output logic            if_ready,
  input  logic            wb_int_we,
  input  logic            wb_fp_we,
  input  logic [4:0]      wb_rd_addr,
  input  logic [XLEN-1:0] wb_int_data,
  input  logic [XLEN-1:0] wb_fp_data,
  input  logic            ex_ld_pend,
  input  logic [4:0]      ex_ld_rd,
  input  logic            ex_ld_fp,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [31:0]     ex_instr,
  output logic [XLEN-1:0] ex_pc_plus4,
  output logic [4:0]      ex_rd_addr,
  output logic [XLEN-1:0] ex_int_rs1,
  output logic [XLEN-1:0] ex_int_rs2,
  output logic [XLEN-1:0] ex_fp_rs1,
  output logic [XLEN-1:0] ex_fp_rs2,
  output logic            stall
);

  localparam bit X0Z = (X0_ZERO != 0);

  logic [4:0] rs1, rs2, rd;
  assign rs1 = if_instr[19:15];
  assign rs2 = if_instr[24:20];
  assign rd  = if_instr[11:7];

  logic [XLEN-1:0] int_rf_q [32];
  logic            int_wr_en;
  logic [XLEN-1:0] int_rs1_d, int_rs2_d;
  logic [XLEN-1:0] fp_rs1_d, fp_rs2_d;

  assign int_wr_en = wb_int_we & ~(X0Z & (wb_rd_addr == 5'd0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) int_rf_q[i] <= '0;
    end else if (int_wr_en) begin
      int_rf_q[wb_rd_addr] <= wb_int_data;
    end
  end

  // Write-through: a same-cycle writeback is visible to the decoding instruction.
  always_comb begin
    int_rs1_d = int_rf_q[rs1];
    int_rs2_d = int_rf_q[rs2];
    if (int_wr_en && wb_rd_addr == rs1) int_rs1_d = wb_int_data;
    if (int_wr_en && wb_rd_addr == rs2) int_rs2_d = wb_int_data;
    if (X0Z && rs1 == 5'd0) int_rs1_d = '0;
    if (X0Z && rs2 == 5'd0) int_rs2_d = '0;
  end

  logic int_haz, fp_haz, hazard;
  assign int_haz = ex_ld_pend & ~ex_ld_fp & ~(X0Z & (ex_ld_rd == 5'd0))
                 & ((ex_ld_rd == rs1) | (ex_ld_rd == rs2));

`ifdef ID_STAGE_FP_RF_EN
  logic [XLEN-1:0] fp_rf_q [32];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) fp_rf_q[i] <= '0;
    end else if (wb_fp_we) begin
      fp_rf_q[wb_rd_addr] <= wb_fp_data;
    end
  end

  always_comb begin
    fp_rs1_d = fp_rf_q[rs1];
    fp_rs2_d = fp_rf_q[rs2];
    if (wb_fp_we && wb_rd_addr == rs1) fp_rs1_d = wb_fp_data;
    if (wb_fp_we && wb_rd_addr == rs2) fp_rs2_d = wb_fp_data;
  end

  assign fp_haz = ex_ld_pend & ex_ld_fp & ((ex_ld_rd == rs1) | (ex_ld_rd == rs2));
`else
  logic unused_fp;
  assign unused_fp = ^{wb_fp_we, wb_fp_data};
  assign fp_rs1_d  = '0;
  assign fp_rs2_d  = '0;
  assign fp_haz    = 1'b0;
`endif

  logic advance, accept;
  assign hazard   = int_haz | fp_haz;
  assign stall    = if_valid & hazard;
  assign advance  = ~ex_valid | ex_ready;
  assign if_ready = advance & ~hazard & ~flush;
  assign accept   = if_valid & if_ready;

  logic            ex_valid_q;
  logic [31:0]     ex_instr_q;
  logic [XLEN-1:0] ex_pc_plus4_q;
  logic [4:0]      ex_rd_addr_q;
  logic [XLEN-1:0] ex_int_rs1_q, ex_int_rs2_q, ex_fp_rs1_q, ex_fp_rs2_q;

  // Flush only kills the valid; payload registers keep their last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q    <= 1'b0;
      ex_instr_q    <= '0;
      ex_pc_plus4_q <= '0;
      ex_rd_addr_q  <= '0;
      ex_int_rs1_q  <= '0;
      ex_int_rs2_q  <= '0;
      ex_fp_rs1_q   <= '0;
      ex_fp_rs2_q   <= '0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (advance) begin
      ex_valid_q <= if_valid & ~hazard;
      if (accept) begin
        ex_instr_q    <= if_instr;
        ex_pc_plus4_q <= if_pc_plus4;
        ex_rd_addr_q  <= rd;
        ex_int_rs1_q  <= int_rs1_d;
        ex_int_rs2_q  <= int_rs2_d;
        ex_fp_rs1_q   <= fp_rs1_d;
        ex_fp_rs2_q   <= fp_rs2_d;
      end
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_instr    = ex_instr_q;
  assign ex_pc_plus4 = ex_pc_plus4_q;
  assign ex_rd_addr  = ex_rd_addr_q;
  assign ex_int_rs1  = ex_int_rs1_q;
  assign ex_int_rs2  = ex_int_rs2_q;
  assign ex_fp_rs1   = ex_fp_rs1_q;
  assign ex_fp_rs2   = ex_fp_rs2_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed self-checking bench for id_stage_pipe
module tb_id_stage_pipe;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc_plus4;
  logic            if_ready;
  logic            wb_int_we, wb_fp_we;
  logic [4:0]      wb_rd_addr;
  logic [XLEN-1:0] wb_int_data, wb_fp_data;
  logic            ex_ld_pend;
  logic [4:0]      ex_ld_rd;
  logic            ex_ld_fp;
  logic            flush;
  logic            ex_ready;
  logic            ex_valid;
  logic [31:0]     ex_instr;
  logic [XLEN-1:0] ex_pc_plus4;
  logic [4:0]      ex_rd_addr;
  logic [XLEN-1:0] ex_int_rs1, ex_int_rs2, ex_fp_rs1, ex_fp_rs2;
  logic            stall;

  int checks   = 0;
  int failures = 0;

  id_stage_pipe #(.XLEN(XLEN), .X0_ZERO(1)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4), .if_ready(if_ready),
    .wb_int_we(wb_int_we), .wb_fp_we(wb_fp_we), .wb_rd_addr(wb_rd_addr),
    .wb_int_data(wb_int_data), .wb_fp_data(wb_fp_data),
    .ex_ld_pend(ex_ld_pend), .ex_ld_rd(ex_ld_rd), .ex_ld_fp(ex_ld_fp), .flush(flush),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc_plus4(ex_pc_plus4),
    .ex_rd_addr(ex_rd_addr), .ex_int_rs1(ex_int_rs1), .ex_int_rs2(ex_int_rs2),
    .ex_fp_rs1(ex_fp_rs1), .ex_fp_rs2(ex_fp_rs2), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wb_int(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_int_we = en; wb_rd_addr = a; wb_int_data = d;
  endtask

  logic [31:0] i1, i2, i3, i4, i5, i6, i7, i8;
  logic [31:0] fp1_exp, fp2_exp;
  logic        fp_haz_exp;

  initial begin
`ifdef ID_STAGE_FP_RF_EN
    fp1_exp = 32'h3F80_0000; fp2_exp = 32'h4000_0000; fp_haz_exp = 1'b1;
`else
    fp1_exp = 32'h0;         fp2_exp = 32'h0;         fp_haz_exp = 1'b0;
`endif
    rst = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc_plus4 = '0;
    wb_int_we = 1'b0; wb_fp_we = 1'b0; wb_rd_addr = '0; wb_int_data = '0; wb_fp_data = '0;
    ex_ld_pend = 1'b0; ex_ld_rd = '0; ex_ld_fp = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    i1 = mk(5'd1, 5'd5, 5'd0);
    i2 = mk(5'd2, 5'd5, 5'd7);
    i3 = mk(5'd4, 5'd0, 5'd0);
    i4 = mk(5'd6, 5'd3, 5'd1);
    i5 = mk(5'd8, 5'd1, 5'd1);
    i6 = mk(5'd10, 5'd9, 5'd0);
    i7 = mk(5'd11, 5'd2, 5'd4);
    i8 = mk(5'd12, 5'd5, 5'd9);

    tick; tick;
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_instr", ex_instr, 0);
    check("rst_ex_rs1", ex_int_rs1, 0);
    check("rst_stall", stall, 0);
    rst = 1'b1;

    // Write x5, then read it back
    wb_int(1'b1, 5'd5, 32'h1234);
    tick;
    wb_int(1'b0, 5'd0, 32'h0);
    if_valid = 1'b1; if_instr = i1; if_pc_plus4 = 32'h104;
    #1 check("i1_if_ready", if_ready, 1);
    tick;
    check("i1_ex_valid", ex_valid, 1);
    check("i1_rs1", ex_int_rs1, 32'h1234);
    check("i1_rd", ex_rd_addr, 5'd1);
    check("i1_pc", ex_pc_plus4, 32'h104);

    // Same-cycle writeback bypass, back-to-back issue
    if_instr = i2; if_pc_plus4 = 32'h108;
    wb_int(1'b1, 5'd7, 32'hCAFE);
    tick;
    check("i2_rs2_bypass", ex_int_rs2, 32'hCAFE);
    check("i2_rs1", ex_int_rs1, 32'h1234);
    check("i2_instr", ex_instr, i2);

    // x0 write is dropped and never bypassed
    if_instr = i3;
    wb_int(1'b1, 5'd0, 32'hFFFF);
    tick;
    wb_int(1'b0, 5'd0, 32'h0);
    check("x0_bypass", ex_int_rs1, 0);
    tick;
    check("x0_read", ex_int_rs1, 0);

    // Load-use on x0 never hazards
    ex_ld_pend = 1'b1; ex_ld_rd = 5'd0;
    #1 check("x0_no_hazard", stall, 0);

    // Load-use hazard on x3 with resolving writeback in the same cycle
    ex_ld_rd = 5'd3; if_instr = i4; if_pc_plus4 = 32'h110;
    wb_int(1'b1, 5'd3, 32'h55);
    #1 check("haz_stall", stall, 1);
    check("haz_if_ready", if_ready, 0);
    tick;
    wb_int(1'b0, 5'd0, 32'h0);
    check("haz_bubble", ex_valid, 0);
    check("haz_hold_instr", ex_instr, i3);
    ex_ld_fp = 1'b1;
    #1 check("ld_fp_int_rs", stall, fp_haz_exp);
    ex_ld_pend = 1'b0; ex_ld_fp = 1'b0;
    #1 check("haz_clear_stall", stall, 0);
    check("haz_clear_ready", if_ready, 1);
    tick;
    check("haz_issue_valid", ex_valid, 1);
    check("haz_issue_rs1", ex_int_rs1, 32'h55);

    // Backpressure for three cycles
    ex_ready = 1'b0; if_instr = i5; if_pc_plus4 = 32'h114;
    for (int k = 0; k < 3; k++) begin
      #1 check("bp_if_ready", if_ready, 0);
      tick;
      check("bp_valid", ex_valid, 1);
      check("bp_instr", ex_instr, i4);
    end
    ex_ready = 1'b1;
    #1 check("bp_release_ready", if_ready, 1);
    tick;
    check("bp_new_instr", ex_instr, i5);

    // Flush while stalled downstream; writeback still lands
    flush = 1'b1; ex_ready = 1'b0; if_instr = i6;
    wb_int(1'b1, 5'd9, 32'h99);
    #1 check("flush_if_ready", if_ready, 0);
    tick;
    wb_int(1'b0, 5'd0, 32'h0);
    check("flush_valid", ex_valid, 0);
    check("flush_not_accepted", ex_instr, i5);
    flush = 1'b0; ex_ready = 1'b1;
    tick;
    check("post_flush_instr", ex_instr, i6);
    check("post_flush_wb", ex_int_rs1, 32'h99);

    // FP file write, then read with bypass on rs2
    if_valid = 1'b0;
    wb_fp_we = 1'b1; wb_rd_addr = 5'd2; wb_fp_data = 32'h3F80_0000;
    tick;
    if_valid = 1'b1; if_instr = i7;
    wb_rd_addr = 5'd4; wb_fp_data = 32'h4000_0000;
    tick;
    wb_fp_we = 1'b0;
    check("fp_rs1", ex_fp_rs1, fp1_exp);
    check("fp_rs2_bypass", ex_fp_rs2, fp2_exp);
    check("fp_not_int", ex_int_rs1, 0);

    // Asynchronous reset mid-stream
    #2 rst = 1'b0;
    #1 check("arst_valid", ex_valid, 0);
    check("arst_instr", ex_instr, 0);
    check("arst_pc", ex_pc_plus4, 0);
    check("arst_fp", ex_fp_rs1, 0);
    tick;
    rst = 1'b1; if_instr = i8;
    #1 check("post_rst_ready", if_ready, 1);
    tick;
    check("post_rst_valid", ex_valid, 1);
    check("post_rst_rf_clear", ex_int_rs1, 0);
    check("post_rst_rf_clear2", ex_int_rs2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
